// File: rtl/alu_seq.sv
// alu_seq: single-issue ALU with valid/ready handshakes; MUL runs as a WIDTH-step shift-add.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             illegal
);
  localparam int S = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state;
  logic [S-1:0] sh, cnt;
  logic [WIDTH:0] sum, dif, shl_t, shr_t;
  logic [WIDTH-1:0] r, mp;
  logic [2*WIDTH-1:0] acc, mc, acc_n;
  logic c, v, bad;
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  always_comb begin
    sh = B[S-1:0];
    sum = {1'b0, A} + {1'b0, B};
    dif = {1'b0, A} - {1'b0, B};
    shl_t = {1'b0, A} << sh;
    shr_t = {A, 1'b0} >> sh;
    acc_n = acc + (mp[0] ? mc : '0);
    r = '0;
    c = 1'b0;
    v = 1'b0;
    bad = 1'b0;
    case (opcode)
      4'h0: begin r = sum[WIDTH-1:0]; c = sum[WIDTH]; v = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]); end
      4'h1: begin r = dif[WIDTH-1:0]; c = dif[WIDTH]; v = (A[WIDTH-1] != B[WIDTH-1]) && (dif[WIDTH-1] != A[WIDTH-1]); end
      4'h2: r = A & B;
      4'h3: r = A | B;
      4'h4: r = A ^ B;
      4'h5: begin r = shl_t[WIDTH-1:0]; c = shl_t[WIDTH]; end
      4'h6: begin r = A >> sh; c = shr_t[0]; end
      4'h7: begin r = $unsigned($signed(A) >>> sh); c = shr_t[0]; end
      4'h8: r = '0;
      default: bad = 1'b1;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      result  <= '0;
      flags   <= '0;
      illegal <= 1'b0;
      acc     <= '0;
      mc      <= '0;
      mp      <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          if (opcode == 4'h8) begin
            state <= BUSY;
            acc   <= '0;
            mc    <= {{WIDTH{1'b0}}, A};
            mp    <= B;
            cnt   <= '0;
          end else begin
            state   <= DONE;
            result  <= r;
            flags   <= {v, r[WIDTH-1], r == '0, c};
            illegal <= bad;
          end
        end
        BUSY: begin
          acc <= acc_n;
          mc  <= mc << 1;
          mp  <= mp >> 1;
          cnt <= cnt + 1'b1;
          // the last step's sum is taken straight from acc_n so DONE follows step WIDTH
          if (cnt == S'(WIDTH - 1)) begin
            state   <= DONE;
            result  <= acc_n[WIDTH-1:0];
            flags   <= {1'b0, acc_n[WIDTH-1], acc_n[WIDTH-1:0] == '0, |acc_n[2*WIDTH-1:WIDTH]};
            illegal <= 1'b0;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors with an arithmetic reference model and a per-cycle output checker.
module tb_alu_seq;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  logic [7:0] A = '0, B = '0;
  logic [3:0] opcode = '0;
  logic in_ready, out_valid, illegal;
  logic [7:0] result;
  logic [3:0] flags;
  int total = 0, bad = 0;
  logic pend = 1'b0;
  logic [7:0] exp_r;
  logic [3:0] exp_f;
  logic exp_i;

  alu_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .opcode(opcode), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // returns {illegal, overflow, negative, zero, carry, result}
  function automatic logic [12:0] model(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    int ua, ub, sa, sb, s, f;
    logic [7:0] r;
    logic c, v, il;
    ua = int'(a); ub = int'(b);
    sa = int'($signed(a)); sb = int'($signed(b));
    s = ub % 8;
    f = 0; c = 1'b0; v = 1'b0; il = 1'b0;
    case (op)
      4'h0: begin f = ua + ub; c = f > 255; v = (sa + sb > 127) || (sa + sb < -128); end
      4'h1: begin f = ua - ub; c = ua < ub; v = (sa - sb > 127) || (sa - sb < -128); end
      4'h2: f = ua & ub;
      4'h3: f = ua | ub;
      4'h4: f = ua ^ ub;
      4'h5: begin f = ua << s; c = (s != 0) && (((ua >> (8 - s)) & 1) == 1); end
      4'h6: begin f = ua >> s; c = (s != 0) && (((ua >> (s - 1)) & 1) == 1); end
      4'h7: begin f = sa >>> s; c = (s != 0) && (((ua >> (s - 1)) & 1) == 1); end
      4'h8: begin f = ua * ub; c = f > 255; end
      default: il = 1'b1;
    endcase
    r = 8'(f & 255);
    return {il, v, r[7], r == 8'h00, c, r};
  endfunction

  always @(negedge clk) if (!rst) begin
    chk("ready_valid_excl", {31'b0, in_ready && out_valid}, 0);
    if (out_valid) begin
      chk("out_expected", {31'b0, pend}, 1);
      chk("result", {24'b0, result}, {24'b0, exp_r});
      chk("flags", {28'b0, flags}, {28'b0, exp_f});
      chk("illegal", {31'b0, illegal}, {31'b0, exp_i});
    end
  end

  task automatic op(input logic [7:0] a, input logic [7:0] b, input logic [3:0] opc,
                    input logic [7:0] er, input logic [3:0] ef, input logic ei, input int hold);
    logic [12:0] m;
    int n;
    m = model(a, b, opc);
    chk("model_result", {24'b0, m[7:0]}, {24'b0, er});
    chk("model_flags", {28'b0, m[11:8]}, {28'b0, ef});
    chk("model_illegal", {31'b0, m[12]}, {31'b0, ei});
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    chk("ready_before", {31'b0, in_ready}, 1);
    A = a; B = b; opcode = opc; in_valid = 1'b1; out_ready = (hold == 0);
    @(posedge clk);
    exp_r = m[7:0]; exp_f = m[11:8]; exp_i = m[12]; pend = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; A = 8'($urandom); B = 8'($urandom); opcode = 4'($urandom);
    n = 1;
    while (!out_valid && n < 50) begin
      chk("busy_not_ready", {31'b0, in_ready}, 0);
      in_valid = n[0];
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    chk("latency", n, (opc == 4'h8) ? 9 : 1);
    repeat (hold) begin
      in_valid = 1'b1;
      @(negedge clk);
      chk("held_valid", {31'b0, out_valid}, 1);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    pend = 1'b0;
    @(negedge clk);
    chk("idle_after", {31'b0, in_ready}, 1);
  endtask

  initial begin
    int n;
    #1;
    chk("rst_result", {24'b0, result}, 0);
    chk("rst_flags", {28'b0, flags}, 0);
    chk("rst_illegal", {31'b0, illegal}, 0);
    chk("rst_valid", {31'b0, out_valid}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("ready_after_rst", {31'b0, in_ready}, 1);
    op(8'hFF, 8'h01, 4'h0, 8'h00, 4'h3, 1'b0, 0);
    op(8'h80, 8'h01, 4'h1, 8'h7F, 4'h8, 1'b0, 0);
    op(8'h01, 8'h02, 4'h1, 8'hFF, 4'h5, 1'b0, 0);
    op(8'h10, 8'h11, 4'h8, 8'h10, 4'h1, 1'b0, 0);
    op(8'h90, 8'h0A, 4'h7, 8'hE4, 4'h4, 1'b0, 0);
    op(8'h81, 8'h01, 4'h5, 8'h02, 4'h1, 1'b0, 0);
    op(8'h5A, 8'hC3, 4'hF, 8'h00, 4'h2, 1'b1, 0);
    op(8'hF0, 8'h3C, 4'h2, 8'h30, 4'h0, 1'b0, 5);
    op(8'h0F, 8'hF0, 4'h3, 8'hFF, 4'h4, 1'b0, 0);
    op(8'hAA, 8'hAA, 4'h4, 8'h00, 4'h2, 1'b0, 0);
    op(8'h81, 8'h09, 4'h6, 8'h40, 4'h1, 1'b0, 0);
    op(8'h7F, 8'h01, 4'h0, 8'h80, 4'hC, 1'b0, 0);
    op(8'h55, 8'h08, 4'h5, 8'h55, 4'h0, 1'b0, 0);
    op(8'hFF, 8'hFF, 4'h8, 8'h01, 4'h1, 1'b0, 3);
    op(8'h0F, 8'h03, 4'h8, 8'h2D, 4'h0, 1'b0, 0);
    op(8'h40, 8'h07, 4'h7, 8'h00, 4'h3, 1'b0, 0);
    op(8'h05, 8'h05, 4'h1, 8'h00, 4'h2, 1'b0, 0);
    op(8'h12, 8'h34, 4'h9, 8'h00, 4'h2, 1'b1, 0);
    // abort a multiply partway through
    @(negedge clk);
    A = 8'h33; B = 8'h05; opcode = 4'h8; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_result", {24'b0, result}, 0);
    chk("abort_flags", {28'b0, flags}, 0);
    chk("abort_illegal", {31'b0, illegal}, 0);
    chk("abort_valid", {31'b0, out_valid}, 0);
    @(negedge clk);
    rst = 1'b0;
    chk("abort_ready", {31'b0, in_ready}, 1);
    n = 0;
    repeat (20) begin @(negedge clk); if (out_valid) n++; end
    chk("abort_no_result", n, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Parameters
REQ-001 SHALL provide parameter WIDTH, default 8, operand/result width; legal values are powers of two, 4 to 32.

Interface
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  operation request valid.
REQ-005 SHALL have port in_ready  output  1  block can accept a request.
REQ-006 SHALL have port A  input  WIDTH  operand A.
REQ-007 SHALL have port B  input  WIDTH  operand B; low log2(WIDTH) bits give the shift amount for shift ops.
REQ-008 SHALL have port opcode  input  4  operation select.
REQ-009 SHALL have port out_valid  output  1  result/flags valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port result  output  WIDTH  registered result.
REQ-012 SHALL have port flags  output  4  registered {overflow, negative, zero, carry}, MSB first.
REQ-013 SHALL have port illegal  output  1  registered; opcode of the held result was undefined.

Function
REQ-014 SHALL implement opcodes: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SHL logical, 0110 SHR logical, 0111 SAR arithmetic, 1000 MUL (low WIDTH bits, unsigned); all others undefined.
REQ-015 SHALL use a 3-state FSM: IDLE, BUSY, DONE.
REQ-016 SHALL drive in_ready high only in IDLE; a request is accepted on a clk edge with in_valid and in_ready both high.
REQ-017 SHALL capture A, B, opcode at acceptance; later input changes SHALL not affect the operation.
REQ-018 Non-MUL ops: IDLE->DONE on acceptance; out_valid high the cycle after acceptance (latency 1).
REQ-019 MUL: IDLE->BUSY on acceptance; shift-add over exactly WIDTH BUSY cycles via internal counter; BUSY->DONE after the last step (out_valid at cycle WIDTH+1 after acceptance).
REQ-020 DONE: out_valid high; result, flags, illegal held stable until out_ready; DONE->IDLE on edge with out_ready high.
REQ-021 in_valid during BUSY or DONE SHALL be ignored (not accepted, not queued).
REQ-022 carry: ADD carry-out; SUB borrow (1 when A<B unsigned); shifts last bit shifted out (0 when amount is 0); MUL 1 when upper WIDTH bits of full product non-zero; logic ops 0.
REQ-023 overflow: ADD/SUB signed two's-complement overflow; all other ops 0.
REQ-024 zero = (result == 0); negative = result[WIDTH-1]; for all ops including undefined.
REQ-025 Undefined opcode: latency 1, result 0, flags zero=1 others 0, illegal=1; illegal=0 for defined ops.
REQ-026 Shift amount SHALL be B mod WIDTH; SAR fills with A[WIDTH-1].
REQ-027 out_valid and in_ready SHALL never be high in the same cycle.

Reset
REQ-028 rst high SHALL immediately (no clock) force IDLE, counter 0, result 0, flags 0, illegal 0, out_valid 0; in_ready high after release.
REQ-029 rst during BUSY or DONE SHALL abort the operation; no result is delivered for it.

Verification (WIDTH=8)
REQ-030 ADD A=0xFF B=0x01, out_ready=1 -> out_valid next cycle, result 0x00, flags carry=1 zero=1 negative=0 overflow=0.
REQ-031 SUB A=0x80 B=0x01 -> result 0x7F, overflow=1, carry=0; SUB A=0x01 B=0x02 -> result 0xFF, carry=1, negative=1.
REQ-032 MUL A=0x10 B=0x11 -> in_ready low 9 cycles, out_valid at cycle 9, result 0x10, carry=1; in_valid pulses during BUSY ignored.
REQ-033 SAR A=0x90 B=0x0A (amount 2) -> result 0xE4, carry=0; SHL A=0x81 B=0x01 -> result 0x02, carry=1.
REQ-034 Backpressure: out_ready=0 for 5 cycles after result -> result/flags stable, in_ready low; out_ready=1 -> IDLE next cycle.
REQ-035 opcode 1111 -> result 0, illegal=1, zero=1; rst asserted mid-MUL -> outputs cleared asynchronously, no out_valid afterwards.
